// File: rtl/fc8_cpu_interrupt_sequencer_pkg.sv
// Shared constants and state encoding for the FC8 CPU interrupt entry sequencer.
package fc8_cpu_interrupt_sequencer_pkg;

  localparam logic [7:0]  FC8_STACK_PAGE = 8'h01;
  localparam logic [15:0] FC8_NMI_VECTOR = 16'hFFFA;
  localparam logic [15:0] FC8_IRQ_VECTOR = 16'hFFFE;

  typedef enum logic [2:0] {
    IseqIdle      = 3'd0,
    IseqPushPch   = 3'd1,
    IseqPushPcl   = 3'd2,
    IseqPushFlags = 3'd3,
    IseqVecLo     = 3'd4,
    IseqVecHi     = 3'd5,
    IseqLoadPc    = 3'd6
  } iseq_state_e;

endpackage

// File: rtl/fc8_cpu_interrupt_sequencer_nmi_edge_latch.sv
// NMI rising-edge detector with a sticky latch; a new edge beats a same-cycle clear.
module fc8_cpu_interrupt_sequencer_nmi_edge_latch (
  input  logic clk_cpu,
  input  logic rst_n,
  input  logic i_nmi_req,
  input  logic i_clear,
  output logic o_latched
);

  logic r_prev;
  logic r_latched;
  logic w_edge;

  assign w_edge = i_nmi_req & ~r_prev;

  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      r_prev    <= 1'b0;
      r_latched <= 1'b0;
    end else begin
      r_prev    <= i_nmi_req;
      r_latched <= w_edge | (r_latched & ~i_clear);
    end
  end

  assign o_latched = r_latched;

endmodule

// File: rtl/fc8_cpu_interrupt_sequencer.sv
// Interrupt entry sequencer: arbitrates NMI/IRQ at instruction boundaries, pushes
// PCH/PCL/FLAGS, fetches the vector and hands the new PC/SP/I back to the core.
module fc8_cpu_interrupt_sequencer
  import fc8_cpu_interrupt_sequencer_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = FC8_STACK_PAGE,
  parameter logic [15:0] NMI_VECTOR = FC8_NMI_VECTOR,
  parameter logic [15:0] IRQ_VECTOR = FC8_IRQ_VECTOR
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic        cpu_nmi_req,
  input  logic        cpu_irq_req,
  input  logic        insn_boundary,
  input  logic        i_flag,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  flags_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        seq_busy,
  output logic        nmi_taken,
  output logic        irq_taken,
  output logic        pc_load,
  output logic [15:0] pc_load_value,
  output logic        sp_load,
  output logic [7:0]  sp_load_value,
  output logic        set_i
);

  iseq_state_e r_state;
  iseq_state_e w_state_next;

  logic [15:0] r_pc;
  logic [7:0]  r_sp;
  logic [7:0]  r_flags;
  logic [15:0] r_vec;
  logic [15:0] r_pc_load_value;
  logic [7:0]  r_sp_load_value;

  logic        w_nmi_latched;
  logic        w_can_accept;
  logic        w_accept_nmi;
  logic        w_accept_irq;
  logic        w_accept;
  logic [7:0]  w_sp_m1;
  logic [7:0]  w_sp_m2;
  logic [15:0] w_vec_p1;

  fc8_cpu_interrupt_sequencer_nmi_edge_latch u_nmi_latch (
    .clk_cpu   (clk_cpu),
    .rst_n     (rst_n),
    .i_nmi_req (cpu_nmi_req),
    .i_clear   (w_accept_nmi),
    .o_latched (w_nmi_latched)
  );

  // rst_n gating keeps the taken pulses quiet while reset is held.
  assign w_can_accept = (r_state == IseqIdle) & insn_boundary & rst_n;
  assign w_accept_nmi = w_can_accept & w_nmi_latched;
  assign w_accept_irq = w_can_accept & ~w_nmi_latched & cpu_irq_req & ~i_flag;
  assign w_accept     = w_accept_nmi | w_accept_irq;

  assign w_sp_m1  = r_sp - 8'd1;
  assign w_sp_m2  = r_sp - 8'd2;
  assign w_vec_p1 = r_vec + 16'd1;

  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 8'h00;
    pc_load      = 1'b0;
    sp_load      = 1'b0;
    set_i        = 1'b0;
    case (r_state)
      IseqIdle: begin
        if (w_accept) w_state_next = IseqPushPch;
      end
      IseqPushPch: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, r_sp};
        mem_wdata = r_pc[15:8];
        if (mem_ready) w_state_next = IseqPushPcl;
      end
      IseqPushPcl: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, w_sp_m1};
        mem_wdata = r_pc[7:0];
        if (mem_ready) w_state_next = IseqPushFlags;
      end
      IseqPushFlags: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, w_sp_m2};
        mem_wdata = r_flags;
        if (mem_ready) w_state_next = IseqVecLo;
      end
      IseqVecLo: begin
        mem_req  = 1'b1;
        mem_addr = r_vec;
        if (mem_ready) w_state_next = IseqVecHi;
      end
      IseqVecHi: begin
        mem_req  = 1'b1;
        mem_addr = w_vec_p1;
        if (mem_ready) w_state_next = IseqLoadPc;
      end
      IseqLoadPc: begin
        pc_load      = 1'b1;
        sp_load      = 1'b1;
        set_i        = 1'b1;
        w_state_next = IseqIdle;
      end
      default: w_state_next = IseqIdle;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      r_state         <= IseqIdle;
      r_pc            <= 16'h0000;
      r_sp            <= 8'h00;
      r_flags         <= 8'h00;
      r_vec           <= 16'h0000;
      r_pc_load_value <= 16'h0000;
      r_sp_load_value <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_pc            <= pc_in;
        r_sp            <= sp_in;
        r_flags         <= flags_in;
        r_vec           <= w_accept_nmi ? NMI_VECTOR : IRQ_VECTOR;
        r_sp_load_value <= sp_in - 8'd3;
      end
      if (r_state == IseqVecLo && mem_ready) r_pc_load_value[7:0]  <= mem_rdata;
      if (r_state == IseqVecHi && mem_ready) r_pc_load_value[15:8] <= mem_rdata;
    end
  end

  assign seq_busy      = (r_state != IseqIdle) | w_accept;
  assign nmi_taken     = w_accept_nmi;
  assign irq_taken     = w_accept_irq;
  assign pc_load_value = r_pc_load_value;
  assign sp_load_value = r_sp_load_value;

endmodule

// File: tb/tb_fc8_cpu_interrupt_sequencer.sv
// Directed bench: expected bus transfers are queued at stimulus time and checked
// as the sequencer issues them; pulses, latency and loaded values checked per test.
module tb_fc8_cpu_interrupt_sequencer;

  logic        clk_cpu = 1'b0;
  logic        rst_n, cpu_nmi_req, cpu_irq_req, insn_boundary, i_flag;
  logic [15:0] pc_in;
  logic [7:0]  sp_in, flags_in;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        seq_busy, nmi_taken, irq_taken, pc_load, sp_load, set_i;
  logic [15:0] pc_load_value;
  logic [7:0]  sp_load_value;

  always #5 clk_cpu = ~clk_cpu;

  fc8_cpu_interrupt_sequencer dut (
    .clk_cpu       (clk_cpu),
    .rst_n         (rst_n),
    .cpu_nmi_req   (cpu_nmi_req),
    .cpu_irq_req   (cpu_irq_req),
    .insn_boundary (insn_boundary),
    .i_flag        (i_flag),
    .pc_in         (pc_in),
    .sp_in         (sp_in),
    .flags_in      (flags_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .seq_busy      (seq_busy),
    .nmi_taken     (nmi_taken),
    .irq_taken     (irq_taken),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .sp_load       (sp_load),
    .sp_load_value (sp_load_value),
    .set_i         (set_i)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } xfer_t;

  xfer_t exp_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int ws_cnt = 0, ws_target = 0, xfers = 0;
  int nmi_cnt = 0, irq_cnt = 0, load_cnt = 0, last_acc = 0, last_load = 0;
  logic        acc_busy;
  logic [15:0] load_pcv;
  logic [7:0]  load_spv;
  logic [1:0]  load_pulses;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFE: return 8'h34;
      16'hFFFF: return 8'h12;
      16'hFFFA: return 8'h78;
      16'hFFFB: return 8'h56;
      default:  return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  assign mem_rdata = mem_rd(mem_addr);
  assign mem_ready = (ws_cnt >= ws_target);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] fl,
                          input logic [15:0] vec);
    logic [7:0]  s1, s2;
    logic [15:0] v1;
    s1 = sp - 8'd1;
    s2 = sp - 8'd2;
    v1 = vec + 16'd1;
    exp_q.push_back({1'b1, 8'h01, sp, pc[15:8]});
    exp_q.push_back({1'b1, 8'h01, s1, pc[7:0]});
    exp_q.push_back({1'b1, 8'h01, s2, fl});
    exp_q.push_back({1'b0, vec, 8'h00});
    exp_q.push_back({1'b0, v1, 8'h00});
  endtask

  task automatic drive(input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] fl);
    pc_in    = pc;
    sp_in    = sp;
    flags_in = fl;
  endtask

  // One clock: sample at the falling edge, update wait-state counter after the rise.
  task automatic tick();
    xfer_t e;
    logic  req_s, rdy_s;
    @(negedge clk_cpu);
    if (mem_req) begin
      if (exp_q.size() == 0) begin
        check("bus_unexpected", {31'd0, mem_req}, 32'd0);
      end else begin
        e = exp_q[0];
        check("bus_we", {31'd0, mem_we}, {31'd0, e.we});
        check("bus_addr", {16'd0, mem_addr}, {16'd0, e.addr});
        if (e.we) check("bus_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
        if (mem_ready) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
    if (nmi_taken || irq_taken) begin
      last_acc = cyc;
      acc_busy = seq_busy;
    end
    if (nmi_taken) nmi_cnt++;
    if (irq_taken) irq_cnt++;
    if (pc_load) begin
      last_load   = cyc;
      load_cnt++;
      load_pcv    = pc_load_value;
      load_spv    = sp_load_value;
      load_pulses = {sp_load, set_i};
    end
    req_s = mem_req;
    rdy_s = mem_req & mem_ready;
    @(posedge clk_cpu);
    #1;
    cyc++;
    if (req_s) ws_cnt = rdy_s ? 0 : ws_cnt + 1;
  endtask

  task automatic run_to_load(input int budget);
    int n, l0;
    n  = 0;
    l0 = load_cnt;
    while (load_cnt == l0 && n < budget) begin
      tick();
      n++;
    end
    if (load_cnt == l0) check("load_timeout", load_cnt, l0 + 1);
  endtask

  initial begin : main
    int x0, i0, n0, l0, t_irq;
    rst_n = 1'b0; cpu_nmi_req = 1'b0; cpu_irq_req = 1'b0; insn_boundary = 1'b0; i_flag = 1'b0;
    drive(16'h0000, 8'h00, 8'h00);
    repeat (2) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, seq_busy}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_pcv", {16'd0, pc_load_value}, 32'd0);
    check("rst_spv", {24'd0, sp_load_value}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: basic IRQ entry with zero wait states.
    drive(16'h1234, 8'hFD, 8'h20);
    cpu_irq_req = 1'b1; insn_boundary = 1'b1;
    push_seq(16'h1234, 8'hFD, 8'h20, 16'hFFFE);
    x0 = xfers; i0 = irq_cnt;
    tick();
    check("t1_irq_taken", irq_cnt - i0, 1);
    check("t1_acc_busy", {31'd0, acc_busy}, 1);
    cpu_irq_req = 1'b0; insn_boundary = 1'b0;
    drive(16'hFFFF, 8'h00, 8'h00);
    run_to_load(20);
    check("t1_latency", last_load - last_acc, 6);
    check("t1_pcv", {16'd0, load_pcv}, 32'h1234);
    check("t1_spv", {24'd0, load_spv}, 32'hFA);
    check("t1_pulses", {30'd0, load_pulses}, 32'd3);
    check("t1_xfers", xfers - x0, 5);
    check("t1_nmi_none", nmi_cnt, 0);
    check("t1_idle", {31'd0, seq_busy}, 0);

    // Test 2: masked IRQ, then NMI beats IRQ at the same boundary.
    i_flag = 1'b1; cpu_irq_req = 1'b1; insn_boundary = 1'b1;
    drive(16'h4444, 8'h80, 8'h01);
    i0 = irq_cnt;
    repeat (3) tick();
    check("t2_masked", irq_cnt - i0, 0);
    check("t2_masked_busy", {31'd0, seq_busy}, 0);
    insn_boundary = 1'b0; cpu_nmi_req = 1'b1;
    tick();
    i_flag = 1'b0; insn_boundary = 1'b1;
    push_seq(16'h4444, 8'h80, 8'h01, 16'hFFFA);
    n0 = nmi_cnt; i0 = irq_cnt;
    tick();
    check("t2_nmi_taken", nmi_cnt - n0, 1);
    check("t2_irq_not", irq_cnt - i0, 0);
    cpu_irq_req = 1'b0; insn_boundary = 1'b0; cpu_nmi_req = 1'b0;
    run_to_load(20);
    check("t2_latency", last_load - last_acc, 6);
    check("t2_pcv", {16'd0, load_pcv}, 32'h5678);
    check("t2_spv", {24'd0, load_spv}, 32'h7D);

    // Test 3: two wait states per access.
    ws_target = 2;
    drive(16'hABCD, 8'h40, 8'hC3);
    cpu_irq_req = 1'b1; insn_boundary = 1'b1;
    push_seq(16'hABCD, 8'h40, 8'hC3, 16'hFFFE);
    x0 = xfers;
    tick();
    cpu_irq_req = 1'b0; insn_boundary = 1'b0;
    run_to_load(40);
    check("t3_latency", last_load - last_acc, 16);
    check("t3_pcv", {16'd0, load_pcv}, 32'h1234);
    check("t3_spv", {24'd0, load_spv}, 32'h3D);
    check("t3_xfers", xfers - x0, 5);
    ws_target = 0;

    // Test 4: stack pointer wrap inside the stack page.
    drive(16'h0102, 8'h01, 8'h0F);
    cpu_irq_req = 1'b1; insn_boundary = 1'b1;
    push_seq(16'h0102, 8'h01, 8'h0F, 16'hFFFE);
    tick();
    cpu_irq_req = 1'b0; insn_boundary = 1'b0;
    run_to_load(20);
    check("t4_spv", {24'd0, load_spv}, 32'hFE);

    // Test 5: NMI edge during an IRQ sequence, second edge in the NMI accept cycle.
    drive(16'h2000, 8'hF0, 8'h00);
    cpu_irq_req = 1'b1; insn_boundary = 1'b1;
    push_seq(16'h2000, 8'hF0, 8'h00, 16'hFFFE);
    n0 = nmi_cnt;
    tick();
    t_irq = last_acc;
    cpu_irq_req = 1'b0;
    tick();
    cpu_nmi_req = 1'b1;
    tick();
    tick();
    cpu_nmi_req = 1'b0;
    run_to_load(20);
    check("t5_nmi_waits", nmi_cnt - n0, 0);
    drive(16'h3000, 8'hED, 8'h04);
    push_seq(16'h3000, 8'hED, 8'h04, 16'hFFFA);
    cpu_nmi_req = 1'b1;
    tick();
    check("t5_nmi_taken", nmi_cnt - n0, 1);
    check("t5_nmi_at_t7", last_acc - t_irq, 7);
    insn_boundary = 1'b0;
    run_to_load(20);
    check("t5_pcv", {16'd0, load_pcv}, 32'h5678);
    check("t5_spv", {24'd0, load_spv}, 32'hEA);
    drive(16'h3100, 8'hEA, 8'h84);
    push_seq(16'h3100, 8'hEA, 8'h84, 16'hFFFA);
    insn_boundary = 1'b1;
    tick();
    check("t5_second_nmi", nmi_cnt - n0, 2);
    insn_boundary = 1'b0; cpu_nmi_req = 1'b0;
    run_to_load(20);
    check("t5_q_empty", exp_q.size(), 0);

    // Test 6: reset while fetching the vector low byte.
    drive(16'h5000, 8'h60, 8'h11);
    cpu_irq_req = 1'b1; insn_boundary = 1'b1;
    push_seq(16'h5000, 8'h60, 8'h11, 16'hFFFE);
    void'(exp_q.pop_back());
    n0 = nmi_cnt; l0 = load_cnt;
    tick();
    cpu_irq_req = 1'b0; insn_boundary = 1'b0; cpu_nmi_req = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0; cpu_nmi_req = 1'b0; insn_boundary = 1'b1;
    tick();
    check("t6_mem_req", {31'd0, mem_req}, 0);
    check("t6_busy", {31'd0, seq_busy}, 0);
    check("t6_addr", {16'd0, mem_addr}, 0);
    check("t6_wdata", {24'd0, mem_wdata}, 0);
    check("t6_pcv", {16'd0, pc_load_value}, 0);
    check("t6_spv", {24'd0, sp_load_value}, 0);
    check("t6_pc_load", {31'd0, pc_load}, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_nmi_cleared", nmi_cnt - n0, 0);
    check("t6_no_load", load_cnt - l0, 0);
    check("t6_busy_after", {31'd0, seq_busy}, 0);
    check("t6_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
